// File: rtl/cunit_pkg.sv
// Shared types and constants for the control unit: state encoding,
// opcode map, register-write source selects and branch conditions.
package cunit_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'b000,
    DECODE    = 3'b001,
    EXECUTE   = 3'b010,
    MEM       = 3'b011,
    WRITEBACK = 3'b100
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_IN,
    CLS_OUT,
    CLS_JUMP,
    CLS_BRANCH
  } cls_t;

  localparam logic [3:0] OP_LOAD   = 4'b1000;
  localparam logic [3:0] OP_STORE  = 4'b1001;
  localparam logic [3:0] OP_IN     = 4'b1010;
  localparam logic [3:0] OP_OUT    = 4'b1011;
  localparam logic [3:0] OP_JUMP   = 4'b1100;
  localparam logic [3:0] OP_BRANCH = 4'b1101;
  localparam logic [3:0] OP_ALUR   = 4'b1110;
  localparam logic [3:0] OP_ALUS   = 4'b1111;

  localparam logic [1:0] MUX_ALU  = 2'd0;
  localparam logic [1:0] MUX_MEM  = 2'd1;
  localparam logic [1:0] MUX_PORT = 2'd2;

  localparam logic [2:0] BR_Z  = 3'b000;
  localparam logic [2:0] BR_NZ = 3'b001;
  localparam logic [2:0] BR_C  = 3'b010;
  localparam logic [2:0] BR_NC = 3'b011;

  typedef struct packed {
    cls_t       cls;
    logic [3:0] alu_op;
    logic       op2;
    logic [1:0] reg_mux;
  } ctrl_t;

  function automatic logic branch_taken(input logic [2:0] cond,
                                        input logic carry, input logic zero);
    case (cond)
      BR_Z:    return zero;
      BR_NZ:   return !zero;
      BR_C:    return carry;
      BR_NC:   return !carry;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cunit_decode.sv
// Combinational opcode/func to control-word table; the FSM registers
// the result while in DECODE.
module cunit_decode
  import cunit_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [2:0] func_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '{cls: CLS_ALU, alu_op: '0, op2: 1'b0, reg_mux: MUX_ALU};
    casez (op_i)
      4'b0???: ctrl_o.alu_op = {op_i[2], 1'b0, op_i[1:0]};
      OP_ALUR: begin
        ctrl_o.alu_op = {1'b0, func_i};
        ctrl_o.op2    = 1'b1;
      end
      OP_ALUS: begin
        ctrl_o.alu_op = {1'b1, func_i};
        ctrl_o.op2    = 1'b1;
      end
      OP_LOAD: begin
        ctrl_o.cls     = CLS_LOAD;
        ctrl_o.reg_mux = MUX_MEM;
      end
      OP_STORE:  ctrl_o.cls = CLS_STORE;
      OP_IN: begin
        ctrl_o.cls     = CLS_IN;
        ctrl_o.reg_mux = MUX_PORT;
      end
      OP_OUT:    ctrl_o.cls = CLS_OUT;
      OP_JUMP:   ctrl_o.cls = CLS_JUMP;
      OP_BRANCH: ctrl_o.cls = CLS_BRANCH;
      default: ;
    endcase
  end

endmodule

// File: rtl/cunit_fsm.sv
// Control unit: sequences punit through FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// drives both bus handshakes and emits registered datapath/PC controls.
module cunit_fsm
  import cunit_pkg::*;
#(
  parameter state_t      RST_STATE = FETCH,
  parameter int unsigned MAX_WAIT  = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ClkEn_i,
  input  logic [3:0] op_i,
  input  logic [2:0] func_i,
  input  logic       carry_i,
  input  logic       zero_i,
  output logic       inst_cyc_o,
  output logic       inst_stb_o,
  input  logic       inst_ack_i,
  output logic       data_cyc_o,
  output logic       data_stb_o,
  output logic       data_we_o,
  input  logic       data_ack_i,
  output logic       port_rd_o,
  output logic       port_wr_o,
  output logic [1:0] RegMux_c_o,
  output logic       RegWrt_c_o,
  output logic       op2_c_o,
  output logic [3:0] ALUOp_c_o,
  output logic       pc_inc_o,
  output logic       pc_load_o,
  output logic       pc_rel_o,
  output logic [2:0] state_o,
  output logic       bus_err_o
);

  localparam logic       INST_RST  = (RST_STATE == FETCH);
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d, dec;
  logic [7:0] wait_q, wait_d;
  logic       inst_req_q, inst_req_d, data_req_q, data_req_d, data_we_q, data_we_d;
  logic       port_rd_q, port_rd_d, port_wr_q, port_wr_d, reg_wrt_q, reg_wrt_d;
  logic       pc_inc_q, pc_inc_d, pc_load_q, pc_load_d, pc_rel_q, pc_rel_d;
  logic       bus_err_q, bus_err_d, timeout;

  cunit_decode u_decode (
    .op_i   (op_i),
    .func_i (func_i),
    .ctrl_o (dec)
  );

  // Every output is a flop loaded with the value belonging to the state
  // being entered, so pulses line up with state_o in the same cycle.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    wait_d     = wait_q;
    bus_err_d  = bus_err_q;
    inst_req_d = 1'b0;
    data_req_d = 1'b0;
    data_we_d  = 1'b0;
    port_rd_d  = 1'b0;
    port_wr_d  = 1'b0;
    reg_wrt_d  = 1'b0;
    pc_inc_d   = 1'b0;
    pc_load_d  = 1'b0;
    pc_rel_d   = 1'b0;
    timeout    = (MAX_WAIT != 0) && (wait_q == WAIT_LAST);

    case (state_q)
      FETCH: begin
        if (!inst_req_q) begin
          // one idle cycle after a timeout, then the fetch is retried
          inst_req_d = 1'b1;
          wait_d     = '0;
        end else if (inst_ack_i) begin
          wait_d   = '0;
          pc_inc_d = 1'b1;
          state_d  = DECODE;
        end else if (timeout) begin
          wait_d    = '0;
          bus_err_d = 1'b1;
        end else begin
          inst_req_d = 1'b1;
          wait_d     = wait_q + 8'd1;
        end
      end
      DECODE: begin
        ctrl_d    = dec;
        state_d   = EXECUTE;
        port_rd_d = (dec.cls == CLS_IN);
        port_wr_d = (dec.cls == CLS_OUT);
        pc_load_d = (dec.cls == CLS_JUMP);
        pc_rel_d  = (dec.cls == CLS_BRANCH) && branch_taken(func_i, carry_i, zero_i);
      end
      EXECUTE: begin
        case (ctrl_q.cls)
          CLS_ALU, CLS_IN: begin
            state_d   = WRITEBACK;
            reg_wrt_d = 1'b1;
          end
          CLS_LOAD, CLS_STORE: begin
            state_d    = MEM;
            data_req_d = 1'b1;
            data_we_d  = (ctrl_q.cls == CLS_STORE);
          end
          default: begin
            state_d    = FETCH;
            inst_req_d = 1'b1;
          end
        endcase
      end
      MEM: begin
        if (data_ack_i) begin
          wait_d = '0;
          if (ctrl_q.cls == CLS_LOAD) begin
            state_d   = WRITEBACK;
            reg_wrt_d = 1'b1;
          end else begin
            state_d    = FETCH;
            inst_req_d = 1'b1;
          end
        end else if (timeout) begin
          wait_d    = '0;
          bus_err_d = 1'b1;
          state_d   = FETCH;
        end else begin
          data_req_d = 1'b1;
          data_we_d  = data_we_q;
          wait_d     = wait_q + 8'd1;
        end
      end
      WRITEBACK: begin
        state_d    = FETCH;
        inst_req_d = 1'b1;
      end
      default: begin
        state_d    = FETCH;
        inst_req_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RST_STATE;
      ctrl_q     <= '0;
      wait_q     <= '0;
      bus_err_q  <= 1'b0;
      inst_req_q <= INST_RST;
      data_req_q <= 1'b0;
      data_we_q  <= 1'b0;
      port_rd_q  <= 1'b0;
      port_wr_q  <= 1'b0;
      reg_wrt_q  <= 1'b0;
      pc_inc_q   <= 1'b0;
      pc_load_q  <= 1'b0;
      pc_rel_q   <= 1'b0;
    end else if (ClkEn_i) begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      wait_q     <= wait_d;
      bus_err_q  <= bus_err_d;
      inst_req_q <= inst_req_d;
      data_req_q <= data_req_d;
      data_we_q  <= data_we_d;
      port_rd_q  <= port_rd_d;
      port_wr_q  <= port_wr_d;
      reg_wrt_q  <= reg_wrt_d;
      pc_inc_q   <= pc_inc_d;
      pc_load_q  <= pc_load_d;
      pc_rel_q   <= pc_rel_d;
    end
  end

  assign inst_cyc_o = inst_req_q;
  assign inst_stb_o = inst_req_q;
  assign data_cyc_o = data_req_q;
  assign data_stb_o = data_req_q;
  assign data_we_o  = data_we_q;
  assign port_rd_o  = port_rd_q;
  assign port_wr_o  = port_wr_q;
  assign RegMux_c_o = ctrl_q.reg_mux;
  assign RegWrt_c_o = reg_wrt_q;
  assign op2_c_o    = ctrl_q.op2;
  assign ALUOp_c_o  = ctrl_q.alu_op;
  assign pc_inc_o   = pc_inc_q;
  assign pc_load_o  = pc_load_q;
  assign pc_rel_o   = pc_rel_q;
  assign state_o    = state_q;
  assign bus_err_o  = bus_err_q;

endmodule
